adder_resp_pipe: RTL and testbench
==================================

// Module: adder_resp_pipe
// PURPOSE
//  DUT-side responder for the adder stimulus interface: accepts operand pairs A/B from the
//  driver over a valid/ready handshake, computes the WIDTH+1-bit sum in a registered pipeline,
//  and buffers results in an output FIFO that the monitor/scoreboard drains with valid/ready.
//  Sits between the driver clocking block and the monitor; the bench's reference DUT.
// PARAMETERS
//  WIDTH       8   operand width; sum is WIDTH+1 bits (MSB = carry)
//  FIFO_DEPTH  4   result FIFO entries; power of 2, >=2; also max results in flight
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-low reset
//  in_valid   in   1          operand pair A/B valid
//  in_ready   out  1          responder can accept an operand pair
//  A          in   WIDTH      operand A
//  B          in   WIDTH      operand B
//  out_valid  out  1          sum valid (FIFO non-empty)
//  out_ready  in   1          consumer accepts sum
//  sum        out  WIDTH+1    A+B, zero-extended, unsigned
//  txn_count  out  16         number of sums popped since reset, wraps
// BEHAVIOUR
//  - Reset (reset==0, async): s1_valid=0, FIFO empty, out_valid=0, sum=0, txn_count=0,
//    in_ready=0 while reset asserted; all in-flight data discarded. Deassert is sync to clk.
//  - Accept: in_valid && in_ready at edge N -> A,B captured into stage-1 register, s1_valid=1.
//  - Compute: at edge N+1, A+B (WIDTH+1 bits, no truncation) written into FIFO tail;
//    out_valid=1 from cycle after edge N+1 if FIFO was empty. Latency accept->out_valid: 2 clk.
//  - Throughput: 1 pair/clk when out_ready held high.
//  - Credit rule: inflight = s1_valid + fifo_count; in_ready = (inflight < FIFO_DEPTH),
//    combinational from registers only (no path from in_valid/out_ready). FIFO never overflows;
//    a write into a full FIFO is impossible by construction (assert in sim).
//  - Pop: out_valid && out_ready -> head advances, txn_count += 1 (mod 2^16).
//  - sum shows FIFO head combinationally; holds stable while out_valid && !out_ready.
//    When empty, sum holds last popped value (0 after reset).
//  - Simultaneous FIFO write and pop same edge: count unchanged, both pointers advance;
//    write-to-empty with pop impossible (out_valid=0), result appears next cycle.
//  - Pointers wrap modulo FIFO_DEPTH; full/empty via count register, not pointer compare.
//  - in_valid without in_ready: operands ignored, must be held by driver (AXI-style).
//  - A/B are X-tolerant when in_valid=0; never captured.
//  - No state machine beyond pipeline valid bit and FIFO count; no drop/error paths.
// TESTING
//  1 Reset: reset=0 mid-stream with 3 results buffered -> out_valid=0, sum=0, txn_count=0
//    same cycle; after release, in_ready=1 next clk, no stale sum emerges.
//  2 Single: A=8'hFF,B=8'h01 accepted edge N, out_ready=1 -> out_valid in cycle after N+1,
//    sum=9'h100, txn_count=1.
//  3 Streaming: pairs (i,2i) for i=0..15 back-to-back, out_ready=1 -> 16 sums 3i in order,
//    in_ready never drops, txn_count=16.
//  4 Backpressure: out_ready=0, in_valid=1 continuous -> exactly 4 accepts, then in_ready=0;
//    sums held stable; raise out_ready -> 4 pops in order, in_ready returns after first pop.
//  5 Simultaneous push/pop at full-1 with random out_ready toggling, 1000 pairs -> scoreboard
//    matches all, no loss/duplication; pointer wrap exercised.
//  6 Counter wrap: 65537 pops -> txn_count=1.

Source files
------------

// File: rtl/adder_resp_pipe.sv
// -----------------------------------------------------------------------------
// adder_resp_pipe
//
// Responder for the adder stimulus interface. Operand pairs arrive over a
// valid/ready handshake, are registered in a single pipeline stage, summed to
// WIDTH+1 bits (MSB = carry) and written into a small result FIFO that the
// consumer drains with its own valid/ready handshake.
//
// Admission is credit based: a pair is accepted only while the number of
// results already committed (pipeline stage + FIFO occupancy) is below the
// FIFO depth, so the FIFO can never be written while full.
//
// Parameters
//   WIDTH       operand width; sum is WIDTH+1 bits
//   FIFO_DEPTH  result FIFO entries, power of two and >= 2
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  pair can be accepted (registers only, no input paths)
//   A, B       in   operands, ignored unless in_valid && in_ready
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer takes the head result
//   sum        out  FIFO head, or last popped result when empty (0 after reset)
//   txn_count  out  results popped since reset, wraps at 2^16
// -----------------------------------------------------------------------------
module adder_resp_pipe #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic [15:0]      txn_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    // Stage 1: captured operands
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, b_q;

    // Result FIFO
    logic [WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    // Output side
    logic [WIDTH:0]   last_q;
    logic [15:0]      txn_q, txn_d;

    // Held low through reset and set on the first clock after release so that
    // in_ready stays low while reset is asserted and rises one clock later.
    logic             rst_done_q;

    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [CW:0]      inflight;
    logic [WIDTH:0]   s1_sum;

    // ------------------------------------------------------------------------
    // Handshake and credit logic
    // ------------------------------------------------------------------------
    always_comb begin
        fifo_empty = (count_q == '0);
        inflight   = {1'b0, count_q} + {{CW{1'b0}}, s1_valid_q};
        in_ready   = rst_done_q && (inflight < DEPTH_C);
        out_valid  = !fifo_empty;
        accept     = in_valid && in_ready;
        push       = s1_valid_q;
        pop        = out_valid && out_ready;
        s1_sum     = {1'b0, a_q} + {1'b0, b_q};
    end

    // ------------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------------
    always_comb begin
        s1_valid_d = accept;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        txn_d      = txn_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            txn_d    = txn_q + 16'd1;
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_done_q <= 1'b0;
            s1_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            txn_q      <= '0;
            last_q     <= '0;
        end else begin
            rst_done_q <= 1'b1;
            s1_valid_q <= s1_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            txn_q      <= txn_d;
            if (pop) begin
                last_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers (no reset needed: contents are qualified by
    // s1_valid_q / count_q)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= A;
            b_q <= B;
        end
        if (push) begin
            mem_q[wr_ptr_q] <= s1_sum;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        sum       = fifo_empty ? last_q : mem_q[rd_ptr_q];
        txn_count = txn_q;
    end

    // The credit rule guarantees the stage-1 result always has a FIFO slot.
    a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
        !(s1_valid_q && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_adder_resp_pipe.sv
module tb_adder_resp_pipe;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W:0]     sum;
    logic [15:0]    txn_count;

    always #5 clk = ~clk;

    adder_resp_pipe #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .txn_count (txn_count)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [W:0]  exp_q[$];
    int unsigned pops_model = 0;
    int unsigned stalls = 0;
    bit          toggling = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the result of a pair is simply its unsigned sum, WIDTH+1 bits.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned s;
        s = int'(a) + int'(b);
        return s[W:0];
    endfunction

    // Monitor: every pop is checked against the oldest outstanding expectation,
    // and the pop counter against the number of pops seen so far.
    initial begin : monitor
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", 32'(sum), 32'(e));
                end
                check("txn_count_pre_pop", 32'(txn_count), pops_model & 32'hFFFF);
                pops_model++;
            end
        end
    end

    // Random backpressure source for the mixed-traffic phase.
    initial begin : toggler
        forever begin
            @(posedge clk);
            #1;
            if (toggling) out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // Presents one pair, holds it until accepted, records its expected result.
    task automatic drive_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned w;
        w = 0;
        in_valid = 1'b1;
        A = a;
        B = b;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ref_sum(a, b));
                break;
            end
            stalls++;
            w++;
            if (w > 500) begin
                check("accept_timeout", w, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
    endtask

    task automatic drain(input string name);
        int unsigned w;
        w = 0;
        while (exp_q.size() != 0 && w < 1000) begin
            @(posedge clk);
            w++;
        end
        check(name, exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d compared, required completion", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned acc;

        // ---------------- power-on reset ----------------
        #1 reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_txn", 32'(txn_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        check("rel_in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready_after_edge", 32'(in_ready), 32'd1);

        // ---------------- single pair, carry out ----------------
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A = 8'hFF;
        B = 8'h01;
        @(negedge clk);
        check("single_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(ref_sum(8'hFF, 8'h01));
        @(posedge clk);             // edge N: accepted
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("single_valid_after_N", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("single_valid_after_N1", 32'(out_valid), 32'd1);
        check("single_sum", 32'(sum), 32'h100);
        @(posedge clk);
        #1;
        check("single_txn", 32'(txn_count), 32'd1);

        // ---------------- streaming ----------------
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            drive_pair(W'(i), W'(2 * i));
        end
        check("stream_no_stall", stalls, 32'd0);
        drain("stream_drain");
        check("stream_txn", 32'(txn_count), 32'd17);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        A = W'($urandom);
        B = W'($urandom);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (in_ready) begin
                acc++;
                exp_q.push_back(ref_sum(A, B));
                @(posedge clk);
                #1;
                A = W'($urandom);
                B = W'($urandom);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        check("bp_accepts", acc, 32'd4);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_sum_held", 32'(sum), 32'(exp_q[0]));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_before_pop", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("bp_in_ready_after_pop", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        drain("bp_drain");
        check("bp_txn", 32'(txn_count), 32'd21);

        // ---------------- random backpressure, 1000 pairs ----------------
        toggling = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            drive_pair(W'($urandom), W'($urandom));
        end
        toggling = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain("rand_drain");
        check("rand_txn", 32'(txn_count), 32'd1021);

        // ---------------- reset mid-stream ----------------
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_pair(W'($urandom), W'($urandom));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_txn", 32'(txn_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        pops_model = 0;
        @(posedge clk);
        #3 reset = 1'b1;
        check("mid_rel_in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rel_in_ready_after_edge", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mid_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // ---------------- pop counter wrap ----------------
        for (int i = 0; i < 65537; i++) begin
            drive_pair(W'($urandom), W'($urandom));
        end
        drain("wrap_drain");
        check("wrap_txn", 32'(txn_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
